// File: rtl/freq_input_conditioner.sv
// ---------------------------------------------------------------------------
// freq_input_conditioner
//
// Front-end for the frequency counter.  The raw asynchronous measured signal
// is brought into the CLK domain through a plain flip-flop synchroniser.  It
// is then debounced by a four-state filter that only lets clean_out follow
// the synchronised level after FILTER_LEN consecutive differing samples.
// Every accepted transition produces a one-cycle rise or fall strobe.
// Pulses that start a pending transition but collapse before it completes
// are counted as glitches in a saturating diagnostic counter.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FILTER_LEN   consecutive differing samples needed to toggle (>= 1)
//   CNT_W        width of glitch_count
//
// Ports:
//   CLK           system clock, everything on the rising edge
//   RST           synchronous active-high reset, overrides all other inputs
//   IN            raw asynchronous input under measurement
//   en            filter enable; low freezes filter state and outputs
//   glitch_clr    synchronous clear of glitch_count (wins over increment)
//   clean_out     filtered, synchronised level for the frequency counter
//   rise_pulse    one-cycle strobe when clean_out goes 0->1
//   fall_pulse    one-cycle strobe when clean_out goes 1->0
//   glitch_count  saturating count of rejected pulses
// ---------------------------------------------------------------------------
module freq_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN,
    input  logic             en,
    input  logic             glitch_clr,
    output logic             clean_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] glitch_count
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FILTER_LAST = FCNT_W'(FILTER_LEN);
    localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic                   sync_q;
    state_t                 state_q, state_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic [FCNT_W-1:0]      fcnt_inc;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       glitch_q, glitch_d;
    logic                   glitch_inc;

    // Synchroniser: a bare shift register, IN enters at bit 0 and the
    // oldest sample leaves from the top bit.  It keeps running while the
    // filter is disabled so that re-enabling starts from a fresh level.
    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], IN};
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Filter next-state logic.  A PEND state counts agreeing samples; the
    // transition completes on the sample that brings the count up to
    // FILTER_LEN.  Falling back to the old STABLE state is a glitch.
    // Disabling the filter abandons any pending transition without counting
    // it and suppresses the strobes.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        clean_d    = clean_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        fcnt_inc   = fcnt_q + FCNT_ONE;

        if (!en) begin
            fcnt_d = '0;
            if (state_q == PEND_HIGH) begin
                state_d = STABLE_LOW;
            end else if (state_q == PEND_LOW) begin
                state_d = STABLE_HIGH;
            end
        end else begin
            case (state_q)
                STABLE_LOW: begin
                    if (sync_q) begin
                        if (FILTER_LEN == 1) begin
                            state_d = STABLE_HIGH;
                            clean_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = PEND_HIGH;
                            fcnt_d  = FCNT_ONE;
                        end
                    end
                end
                PEND_HIGH: begin
                    if (sync_q) begin
                        if (fcnt_inc == FILTER_LAST) begin
                            state_d = STABLE_HIGH;
                            clean_d = 1'b1;
                            rise_d  = 1'b1;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end else begin
                        state_d    = STABLE_LOW;
                        fcnt_d     = '0;
                        glitch_inc = 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_q) begin
                        if (FILTER_LEN == 1) begin
                            state_d = STABLE_LOW;
                            clean_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = PEND_LOW;
                            fcnt_d  = FCNT_ONE;
                        end
                    end
                end
                PEND_LOW: begin
                    if (!sync_q) begin
                        if (fcnt_inc == FILTER_LAST) begin
                            state_d = STABLE_LOW;
                            clean_d = 1'b0;
                            fall_d  = 1'b1;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end else begin
                        state_d    = STABLE_HIGH;
                        fcnt_d     = '0;
                        glitch_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = STABLE_LOW;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // Glitch counter: clear has priority, otherwise count up and stick at
    // all-ones rather than wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_inc && (glitch_q != {CNT_W{1'b1}})) begin
            glitch_d = glitch_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_chain_q <= '0;
            state_q      <= STABLE_LOW;
            fcnt_q       <= '0;
            clean_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            glitch_q     <= '0;
        end else begin
            sync_chain_q <= sync_chain_d;
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            clean_q      <= clean_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            glitch_q     <= glitch_d;
        end
    end

    assign clean_out    = clean_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_freq_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_freq_input_conditioner
//
// Directed bench for freq_input_conditioner.  Three instances share the
// clock and reset: the default configuration, a CNT_W=2 copy driven with
// the same input for saturation, and a FILTER_LEN=1 copy with its own input
// for the square-wave tracking case.  Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_freq_input_conditioner;

    logic        clk;
    logic        rst;
    logic        in_sig;
    logic        en;
    logic        clr;
    logic        clr_sat;
    logic        in_f1;
    logic        clr_f1;

    logic        clean, rise, fall;
    logic [15:0] gcnt;
    logic        clean_sat, rise_sat, fall_sat;
    logic [1:0]  gcnt_sat;
    logic        clean_f1, rise_f1, fall_f1;
    logic [15:0] gcnt_f1;

    int n_cmp;
    int n_err;

    freq_input_conditioner dut (
        .CLK(clk), .RST(rst), .IN(in_sig), .en(en), .glitch_clr(clr),
        .clean_out(clean), .rise_pulse(rise), .fall_pulse(fall),
        .glitch_count(gcnt)
    );

    freq_input_conditioner #(.CNT_W(2)) dut_sat (
        .CLK(clk), .RST(rst), .IN(in_sig), .en(en), .glitch_clr(clr_sat),
        .clean_out(clean_sat), .rise_pulse(rise_sat), .fall_pulse(fall_sat),
        .glitch_count(gcnt_sat)
    );

    freq_input_conditioner #(.FILTER_LEN(1)) dut_f1 (
        .CLK(clk), .RST(rst), .IN(in_f1), .en(1'b1), .glitch_clr(clr_f1),
        .clean_out(clean_f1), .rise_pulse(rise_f1), .fall_pulse(fall_f1),
        .glitch_count(gcnt_f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: count it and report any difference.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Filter-enable-high glitch of three input cycles; optional coincident
    // clears are raised for the edge on which the glitch is counted.
    task automatic glitch3(input logic with_clr);
        for (int i = 1; i <= 10; i++) begin
            in_sig  = (i <= 3);
            clr     = with_clr && (i == 6);
            clr_sat = with_clr && (i == 6);
            apply_stimulus(1);
            check_output("glitch_clean", {31'd0, clean}, 32'd0);
            check_output("glitch_rise", {31'd0, rise}, 32'd0);
        end
        clr     = 1'b0;
        clr_sat = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        in_sig  = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        clr_sat = 1'b0;
        in_f1   = 1'b0;
        clr_f1  = 1'b0;

        // Reset and idle.
        apply_stimulus(2);
        rst = 1'b0;
        check_output("rst_clean", {31'd0, clean}, 32'd0);
        check_output("rst_rise", {31'd0, rise}, 32'd0);
        check_output("rst_fall", {31'd0, fall}, 32'd0);
        check_output("rst_gcnt", {16'd0, gcnt}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1);
            check_output("idle_clean", {31'd0, clean}, 32'd0);
            check_output("idle_strobe", {30'd0, rise, fall}, 32'd0);
        end
        check_output("idle_gcnt", {16'd0, gcnt}, 32'd0);
        check_output("idle_gcnt_sat", {30'd0, gcnt_sat}, 32'd0);

        // Clean rising step: appears five edges after first capture.
        in_sig = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1);
            check_output("step_up_clean", {31'd0, clean}, {31'd0, (i >= 6)});
            check_output("step_up_rise", {31'd0, rise}, {31'd0, (i == 6)});
            check_output("step_up_fall", {31'd0, fall}, 32'd0);
        end
        in_sig = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1);
            check_output("step_dn_clean", {31'd0, clean}, {31'd0, (i < 6)});
            check_output("step_dn_fall", {31'd0, fall}, {31'd0, (i == 6)});
            check_output("step_dn_rise", {31'd0, rise}, 32'd0);
        end
        check_output("step_gcnt", {16'd0, gcnt}, 32'd0);

        // Five three-cycle glitches; the 2-bit copy saturates at 3.
        for (int g = 1; g <= 5; g++) begin
            glitch3(1'b0);
            check_output("glitch_gcnt", {16'd0, gcnt}, g);
            check_output("glitch_gcnt_sat", {30'd0, gcnt_sat}, (g > 3) ? 32'd3 : g);
        end

        // A pulse of exactly FILTER_LEN cycles is accepted.
        for (int i = 1; i <= 12; i++) begin
            in_sig = (i <= 4);
            apply_stimulus(1);
            check_output("pulse4_clean", {31'd0, clean}, {31'd0, (i >= 6 && i < 10)});
            check_output("pulse4_rise", {31'd0, rise}, {31'd0, (i == 6)});
            check_output("pulse4_fall", {31'd0, fall}, {31'd0, (i == 10)});
        end
        check_output("pulse4_gcnt", {16'd0, gcnt}, 32'd5);
        check_output("pulse4_gcnt_sat", {30'd0, gcnt_sat}, 32'd3);

        // Sixth glitch with clear on the counting edge: clear wins.
        glitch3(1'b1);
        check_output("clrcoin_gcnt", {16'd0, gcnt}, 32'd0);
        check_output("clrcoin_gcnt_sat", {30'd0, gcnt_sat}, 32'd0);
        glitch3(1'b0);
        check_output("after_clr_gcnt", {16'd0, gcnt}, 32'd1);
        check_output("after_clr_gcnt_sat", {30'd0, gcnt_sat}, 32'd1);

        // Disable two cycles into PEND_HIGH: abandoned, not a glitch.
        for (int i = 1; i <= 12; i++) begin
            in_sig = (i <= 4);
            en     = !(i == 5 || i == 6);
            apply_stimulus(1);
            check_output("enpend_clean", {31'd0, clean}, 32'd0);
            check_output("enpend_rise", {31'd0, rise}, 32'd0);
        end
        en = 1'b1;
        check_output("enpend_gcnt", {16'd0, gcnt}, 32'd1);

        // Disable during a held high level; filtering restarts afterwards.
        for (int i = 1; i <= 14; i++) begin
            in_sig = 1'b1;
            en     = !(i >= 5 && i <= 7);
            apply_stimulus(1);
            check_output("restart_clean", {31'd0, clean}, {31'd0, (i >= 11)});
            check_output("restart_rise", {31'd0, rise}, {31'd0, (i == 11)});
        end
        check_output("restart_gcnt", {16'd0, gcnt}, 32'd1);

        // Disabled filter holds clean_out high while the input drops.
        for (int i = 1; i <= 8; i++) begin
            in_sig = 1'b0;
            en     = 1'b0;
            apply_stimulus(1);
            check_output("hold_clean", {31'd0, clean}, 32'd1);
            check_output("hold_fall", {31'd0, fall}, 32'd0);
        end
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(1);
            check_output("reen_clean", {31'd0, clean}, {31'd0, (i < 4)});
            check_output("reen_fall", {31'd0, fall}, {31'd0, (i == 4)});
        end
        check_output("reen_gcnt", {16'd0, gcnt}, 32'd1);

        // Standalone clear on the default instance only.
        clr = 1'b1;
        apply_stimulus(1);
        clr = 1'b0;
        check_output("clr_gcnt", {16'd0, gcnt}, 32'd0);
        check_output("clr_gcnt_sat", {30'd0, gcnt_sat}, 32'd1);

        // Reset while clean_out is high: drops without a fall strobe.
        in_sig = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(1);
            check_output("prerst_clean", {31'd0, clean}, {31'd0, (i >= 6)});
        end
        rst = 1'b1;
        apply_stimulus(1);
        rst = 1'b0;
        check_output("midrst_clean", {31'd0, clean}, 32'd0);
        check_output("midrst_fall", {31'd0, fall}, 32'd0);
        check_output("midrst_rise", {31'd0, rise}, 32'd0);
        check_output("midrst_gcnt_sat", {30'd0, gcnt_sat}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1);
            check_output("postrst_clean", {31'd0, clean}, {31'd0, (i >= 6)});
            check_output("postrst_rise", {31'd0, rise}, {31'd0, (i == 6)});
            check_output("postrst_fall", {31'd0, fall}, 32'd0);
        end
        in_sig = 1'b0;
        apply_stimulus(8);
        check_output("postrst_low", {31'd0, clean}, 32'd0);

        // FILTER_LEN=1: period-10 square wave, clean_out lags by two edges.
        for (int c = 0; c < 40; c++) begin
            in_f1 = ((c % 10) < 5);
            apply_stimulus(1);
            check_output("sq_clean", {31'd0, clean_f1},
                         {31'd0, (c >= 2) && (((c - 2) % 10) < 5)});
            check_output("sq_rise", {31'd0, rise_f1}, {31'd0, ((c % 10) == 2)});
            check_output("sq_fall", {31'd0, fall_f1}, {31'd0, ((c % 10) == 7)});
        end
        check_output("sq_gcnt", {16'd0, gcnt_f1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_input_conditioner.md
Name: freq_input_conditioner

Overview:
Upstream front-end for the frequency counter. It takes the raw asynchronous measured signal and produces the clean, single-clock-domain level and edge pulses that the counter consumes as its IN.
- Synchronises the signal into the CLK domain.
- Rejects pulses shorter than a programmable stable time.
- Emits one-cycle rising/falling edge strobes.
- Keeps a saturating count of rejected glitches for diagnostics.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser chain (legal range >= 2)
FILTER_LEN, 4, consecutive synchronised samples that must differ from clean_out before clean_out toggles (legal range >= 1)
CNT_W, 16, width of glitch_count

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  synchronous, active-high reset
IN  input  1  raw asynchronous signal under measurement
en  input  1  filter enable; when low, filter state and outputs are frozen
glitch_clr  input  1  synchronous clear of glitch_count
clean_out  output  1  filtered, synchronised level; feeds the frequency counter IN
rise_pulse  output  1  one-cycle strobe, asserted in the cycle clean_out goes 0->1
fall_pulse  output  1  one-cycle strobe, asserted in the cycle clean_out goes 1->0
glitch_count  output  CNT_W  number of rejected pulses; saturates at all-ones

Behaviour:
Reset (RST=1 at a CLK edge; overrides all other inputs):
- Synchroniser chain = 0, clean_out = 0, rise_pulse = fall_pulse = 0.
- Filter counter = 0, state = STABLE_LOW, glitch_count = 0.

Synchroniser:
- Plain shift register, runs regardless of en.
- sync_q = last stage.
- No logic between stages.

Filter FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW. Filter counter is internal, width clog2(FILTER_LEN+1).
- STABLE_LOW, sync_q=1:
  - FILTER_LEN=1: go directly to STABLE_HIGH, clean_out=1, rise_pulse=1.
  - Otherwise: go to PEND_HIGH, counter=1.
- PEND_HIGH, sync_q=1: counter+1. When counter reaches FILTER_LEN, go to STABLE_HIGH, clean_out=1, rise_pulse=1, counter=0.
- PEND_HIGH, sync_q=0: go to STABLE_LOW, counter=0, glitch_count+1.
- STABLE_HIGH / PEND_LOW: mirror image of the above, driving clean_out=0 and fall_pulse.

Latency:
- A level change on IN captured by stage 0 at edge k appears on clean_out at edge k + SYNC_STAGES - 1 + FILTER_LEN.
- Defaults: edge k+5.
- rise_pulse/fall_pulse are registered and change at the same edge as clean_out. They are high for exactly one cycle.
- Two strobes are never asserted in consecutive cycles when FILTER_LEN >= 2.

Glitch counter:
- Increments only on PEND->STABLE-same-level returns.
- Saturates at 2^CNT_W-1; no wrap.
- glitch_clr=1 sets it to 0. If glitch_clr and an increment coincide, clear wins and the result is 0.

Enable:
- en=0: FSM state, clean_out and glitch_count hold; strobes forced to 0.
- en=0 during PEND_x: counter reset to 0 and state returns to the corresponding STABLE_x. No glitch is counted.
- en=1 again: filtering restarts from the current sync_q.

Reset mid-operation: reset while in PEND_HIGH or STABLE_HIGH returns to STABLE_LOW with clean_out=0. No fall_pulse is generated.

Test Plan:
- Reset then idle: RST high 2 cycles, IN=0 -> clean_out=0, no strobes, glitch_count=0 for 20 cycles.
- Clean step, defaults: IN 0->1 before edge 10, held -> clean_out=1 and rise_pulse=1 at edge 15 only. IN 1->0 before edge 30 -> fall_pulse=1 at edge 35 only.
- Glitch reject: IN high for exactly 3 cycles, then low -> clean_out stays 0, no rise_pulse, glitch_count=1. Repeat 5 times -> glitch_count=5.
- Saturation and clear: CNT_W=2, 5 glitches -> glitch_count=3. Then glitch_clr coincident with a 6th glitch -> glitch_count=0.
- Enable/reset mid-pend: en=0 two cycles into PEND_HIGH -> state STABLE_LOW, glitch_count unchanged. RST while clean_out=1 -> clean_out=0 next edge, fall_pulse=0.
- FILTER_LEN=1, square wave of period 10 cycles on IN -> clean_out tracks IN delayed 2 cycles, one rise_pulse and one fall_pulse per period, glitch_count=0.
